// File: rtl/multicycle_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator machine: owns PC/MAR/MBR/IR/ACC,
// drives the external ALU and runs a req/ready memory handshake with a wait-state watchdog.
module multicycle_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  halted,
  output logic                  fault,
  output logic                  retire,
  output logic                  pc_wrap
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXECUTE, S_WRITE, S_HALTED, S_FAULT
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, mar_q;
  logic [DATA_WIDTH-1:0] mbr_q, ir_q, acc_q;
  logic [WW-1:0]         wait_q;
  logic [3:0]            alu_op_q;
  logic                  retire_q, wrap_q;

  logic [3:0]            opcode_d, fetch_op_d;
  logic [ADDR_WIDTH-1:0] opaddr_d, pc_inc_d;
  logic                  req_d, timeout_d;

  function automatic logic [3:0] alu_map(input logic [3:0] op);
    case (op)
      4'h3:    return 4'b0000;
      4'h4:    return 4'b0001;
      4'h5:    return 4'b1000;
      4'h6:    return 4'b1001;
      4'h7:    return 4'b1010;
      4'hA:    return 4'b0100;
      4'hB:    return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  assign opcode_d   = ir_q[DATA_WIDTH-1 -: 4];
  assign fetch_op_d = mem_rdata[DATA_WIDTH-1 -: 4];
  assign opaddr_d   = ir_q[ADDR_WIDTH-1:0];
  assign pc_inc_d   = pc_q + ADDR_WIDTH'(1);
  assign req_d      = (state_q == S_FETCH) || (state_q == S_OPERAND) || (state_q == S_WRITE);
  // Fault fires on the wait cycle that would bring the count to MAX_WAIT; a ready in that cycle wins.
  assign timeout_d  = (MAX_WAIT != 0) && req_d && !mem_ready && (wait_q == WW'(MAX_WAIT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      mar_q    <= '0;
      mbr_q    <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      wait_q   <= '0;
      alu_op_q <= '0;
      retire_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      wrap_q   <= 1'b0;
      if (req_d && !mem_ready) wait_q <= wait_q + WW'(1);
      if (timeout_d) begin
        state_q  <= S_FAULT;
        alu_op_q <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_HALTED: begin
            if (start) begin
              mar_q   <= pc_q;
              wait_q  <= '0;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (mem_ready) begin
              ir_q     <= mem_rdata;
              pc_q     <= pc_inc_d;
              wrap_q   <= &pc_q;
              // Shifts execute in DECODE, so their ALU code must be ready on entry.
              alu_op_q <= (fetch_op_d == 4'hA || fetch_op_d == 4'hB) ? alu_map(fetch_op_d) : 4'b0000;
              state_q  <= S_DECODE;
            end
          end
          S_DECODE: begin
            alu_op_q <= '0;
            wait_q   <= '0;
            case (opcode_d)
              4'h0: begin
                retire_q <= 1'b1;
                state_q  <= S_HALTED;
              end
              4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                mar_q   <= opaddr_d;
                state_q <= S_OPERAND;
              end
              4'h2: begin
                mar_q   <= opaddr_d;
                state_q <= S_WRITE;
              end
              default: begin
                retire_q <= 1'b1;
                state_q  <= S_FETCH;
                mar_q    <= pc_q;
                if (opcode_d == 4'h8 || (opcode_d == 4'h9 && acc_q == '0)) begin
                  pc_q  <= opaddr_d;
                  mar_q <= opaddr_d;
                end
                if (opcode_d == 4'hA || opcode_d == 4'hB) acc_q <= alu_result;
              end
            endcase
          end
          S_OPERAND: begin
            if (mem_ready) begin
              mbr_q    <= mem_rdata;
              alu_op_q <= alu_map(opcode_d);
              state_q  <= S_EXECUTE;
            end
          end
          S_EXECUTE: begin
            acc_q    <= (opcode_d == 4'h1) ? mbr_q : alu_result;
            alu_op_q <= '0;
            retire_q <= 1'b1;
            mar_q    <= pc_q;
            wait_q   <= '0;
            state_q  <= S_FETCH;
          end
          S_WRITE: begin
            if (mem_ready) begin
              retire_q <= 1'b1;
              mar_q    <= pc_q;
              wait_q   <= '0;
              state_q  <= S_FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_req   = req_d;
  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = mar_q;
  assign mem_wdata = (state_q == S_WRITE) ? acc_q : '0;
  assign alu_op    = alu_op_q;
  assign alu_a     = acc_q;
  assign alu_b     = mbr_q;
  assign acc_out   = acc_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign halted    = (state_q == S_HALTED);
  assign fault     = (state_q == S_FAULT);
  assign retire    = retire_q;
  assign pc_wrap   = wrap_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with a behavioural memory and ALU model.
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        ready_en = 1'b1;
  logic        mem_req, mem_we, halted, fault, retire, pc_wrap;
  logic [11:0] mem_addr, pc_out;
  logic [15:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result, acc_out, ir_out;
  logic [3:0]  alu_op;

  logic [15:0] mem [0:4095];
  int          n_checks = 0;
  int          n_fail = 0;
  int          retire_cnt, wrap_cnt, wr_cnt;
  logic [11:0] last_wr_addr;
  logic [15:0] last_wr_data;

  multicycle_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .MAX_WAIT(15)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(ready_en),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .acc_out(acc_out), .pc_out(pc_out), .ir_out(ir_out),
    .halted(halted), .fault(fault), .retire(retire), .pc_wrap(pc_wrap)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      default: alu_result = 16'h0000;
    endcase
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt   <= 0;
      wrap_cnt     <= 0;
      wr_cnt       <= 0;
      last_wr_addr <= '0;
      last_wr_data <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 1;
      if (pc_wrap) wrap_cnt <= wrap_cnt + 1;
      if (mem_req && mem_we && ready_en) begin
        wr_cnt       <= wr_cnt + 1;
        last_wr_addr <= mem_addr;
        last_wr_data <= mem_wdata;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hC000;
  endtask

  task automatic do_reset();
    @(negedge clock);
    start    = 1'b0;
    ready_en = 1'b1;
    reset_n  = 1'b0;
    step(2);
    reset_n  = 1'b1;
  endtask

  // Pulse start for one clock; returns at the negedge after the sampling edge.
  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    clear_mem();
    do_reset();
    check("rst_req", mem_req, 0);
    check("rst_pc", pc_out, 0);
    check("rst_acc", acc_out, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    step(2);
    check("idle_no_req", mem_req, 0);

    // 1: LOAD/ADD/STORE/HALT program
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'h2012; mem[3] = 16'h0000;
    mem[16'h10] = 16'h0005; mem[16'h11] = 16'h0007;
    do_reset();
    kick();
    check("t1_fetch_req", mem_req, 1);
    check("t1_fetch_addr", mem_addr, 12'h000);
    step(12);
    check("t1_not_halted_yet", halted, 0);
    step(1);
    check("t1_halted", halted, 1);
    step(1);
    check("t1_acc", acc_out, 16'h000C);
    check("t1_pc", pc_out, 12'h004);
    check("t1_retires", retire_cnt, 4);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_wr_addr", last_wr_addr, 12'h012);
    check("t1_wr_data", last_wr_data, 16'h000C);
    kick();
    check("t1_resume_addr", mem_addr, 12'h004);
    check("t1_resume_req", mem_req, 1);

    // 2a: JZ taken with ACC=0
    clear_mem();
    mem[0] = 16'h9020;
    do_reset();
    kick();
    step(2);
    check("t2a_fetch_addr", mem_addr, 12'h020);
    check("t2a_pc", pc_out, 12'h020);
    check("t2a_req", mem_req, 1);

    // 2b: JZ not taken with ACC=1
    clear_mem();
    mem[0] = 16'h1030; mem[1] = 16'h9020; mem[16'h30] = 16'h0001;
    do_reset();
    kick();
    step(4);
    check("t2b_acc", acc_out, 16'h0001);
    step(2);
    check("t2b_fetch_addr", mem_addr, 12'h002);
    check("t2b_pc", pc_out, 12'h002);

    // 3: three wait states during OPERAND
    clear_mem();
    mem[0] = 16'h1010; mem[16'h10] = 16'hBEEF;
    do_reset();
    kick();
    step(2);
    ready_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_req", mem_req, 1);
      check("t3_addr", mem_addr, 12'h010);
      check("t3_we", mem_we, 0);
      if (i < 3) step(1);
    end
    ready_en = 1'b1;
    step(2);
    check("t3_acc", acc_out, 16'hBEEF);
    check("t3_fault", fault, 0);

    // 4: watchdog in FETCH
    clear_mem();
    do_reset();
    ready_en = 1'b0;
    kick();
    step(14);
    check("t4_no_fault_yet", fault, 0);
    check("t4_req_waiting", mem_req, 1);
    step(1);
    check("t4_fault", fault, 1);
    check("t4_req_dropped", mem_req, 0);
    ready_en = 1'b1;
    kick();
    step(1);
    check("t4_fault_sticky", fault, 1);
    check("t4_start_ignored", mem_req, 0);
    #2 reset_n = 1'b0;
    #1 check("t4_fault_cleared", fault, 0);
    step(1);
    reset_n = 1'b1;

    // 5: PC wrap
    clear_mem();
    mem[0] = 16'h8FFF; mem[16'hFFF] = 16'hC000;
    do_reset();
    kick();
    step(2);
    check("t5_fetch_fff", mem_addr, 12'hFFF);
    step(1);
    check("t5_wrap_pulse", pc_wrap, 1);
    check("t5_pc_zero", pc_out, 12'h000);
    step(1);
    check("t5_wrap_once", pc_wrap, 0);
    check("t5_fetch_zero", mem_addr, 12'h000);
    check("t5_wrap_cnt", wrap_cnt, 1);

    // 6: asynchronous reset in the middle of a WRITE
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'h2012; mem[16'h10] = 16'h1234;
    do_reset();
    kick();
    step(6);
    ready_en = 1'b0;
    step(1);
    check("t6_write_req", mem_req, 1);
    check("t6_write_we", mem_we, 1);
    check("t6_wdata", mem_wdata, 16'h1234);
    #2 reset_n = 1'b0;
    #1;
    check("t6_req_async", mem_req, 0);
    check("t6_acc_zero", acc_out, 0);
    check("t6_pc_zero", pc_out, 0);
    check("t6_ir_zero", ir_out, 0);
    check("t6_addr_zero", mem_addr, 0);
    step(1);
    reset_n  = 1'b1;
    ready_en = 1'b1;
    step(3);
    check("t6_idle", mem_req, 0);
    check("t6_no_retire", retire_cnt, 0);
    check("t6_no_write", wr_cnt, 0);

    // 7: SHL in DECODE then XOR through EXECUTE
    clear_mem();
    mem[0] = 16'h1010; mem[1] = 16'hA000; mem[2] = 16'h7011; mem[3] = 16'h0000;
    mem[16'h10] = 16'h00F0; mem[16'h11] = 16'h0FFF;
    do_reset();
    kick();
    step(5);
    check("t7_shl_op", alu_op, 4'b0100);
    step(1);
    check("t7_shl_acc", acc_out, 16'h01E0);
    step(3);
    check("t7_xor_op", alu_op, 4'b1010);
    step(1);
    check("t7_xor_acc", acc_out, 16'h0E1F);
    check("t7_op_idle", alu_op, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
